// File: rtl/meat_draw_pkg.sv
// rtl/meat_draw_pkg.sv - shared widths, FSM encoding and defaults for the meat draw scheduler
//
// Purpose : common constants and types imported by meat_draw_scheduler and
//           sprite_pixel_walker.
// Contents: COLOUR_W / COORD_W pixel field widths, default slot count and
//           sprite size, default slot placement, scheduler state encoding.
package meat_draw_pkg;

    localparam int COLOUR_W  = 9;
    localparam int COORD_W   = 8;

    localparam int N_CH_DEF  = 6;
    localparam int SPR_W_DEF = 16;
    localparam int SPR_H_DEF = 16;

    // Default placement: slots side by side along one row.
    localparam int SLOT_X_STEP = 20;
    localparam int SLOT_Y_DEF  = 0;

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic [COORD_W-1:0] slot_x_default(input int i);
        return COORD_W'(i * SLOT_X_STEP);
    endfunction

    function automatic logic [COORD_W-1:0] slot_y_default(input int i);
        return COORD_W'(SLOT_Y_DEF + 0 * i);
    endfunction

endpackage

// File: rtl/sprite_pixel_walker.sv
// rtl/sprite_pixel_walker.sv - raster px/py counter over a W x H sprite
//
// Purpose : holds the position of the pixel currently presented downstream.
// Ports   : clk, resetn (sync active-low)
//           clear   - restart at (0,0)
//           advance - step to the next pixel in raster order (wraps at the end)
//           px, py  - current pixel offset inside the sprite
//           is_border - current pixel lies on the outer one-pixel ring
//           last    - current pixel is (W-1, H-1)
module sprite_pixel_walker
    import meat_draw_pkg::*;
#(
    parameter int W = SPR_W_DEF,
    parameter int H = SPR_H_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               is_border,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(H - 1);

    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;

    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (clear) begin
            px_d = '0;
            py_d = '0;
        end else if (advance) begin
            if (px_q == X_LAST) begin
                px_d = '0;
                py_d = (py_q == Y_LAST) ? '0 : py_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    assign px        = px_q;
    assign py        = py_q;
    assign is_border = (px_q == '0) || (px_q == X_LAST) || (py_q == '0) || (py_q == Y_LAST);
    assign last      = (px_q == X_LAST) && (py_q == Y_LAST);

endmodule

// File: rtl/meat_draw_scheduler.sv
// rtl/meat_draw_scheduler.sv - round-robin N-slot meat sprite renderer feeding a plot port
//
// Purpose : scans N_CH slots round-robin, redraws any slot whose colours
//           differ from what was last drawn (or is pending), walking its
//           SPR_W x SPR_H sprite one pixel per accepted plot.
// Ports   : clk, resetn (sync active-low)
//           colour_fat, colour_muscle [N_CH*9] - per-slot colours
//           x_base, y_base [N_CH*8]            - per-slot top-left corner
//           plot_ready                         - downstream accepts pixel
//           x_out, y_out, colour_out, plot     - pixel stream
//           cur_ch                             - slot pointer
//           busy                               - high in LOAD or DRAW
// Config  : MDS_FORCE_REFRESH_EN - periodic forced full redraw every
//           REFRESH_PERIOD cycles.
module meat_draw_scheduler
    import meat_draw_pkg::*;
#(
    parameter int N_CH           = N_CH_DEF,
    parameter int SPR_W          = SPR_W_DEF,
    parameter int SPR_H          = SPR_H_DEF,
    parameter int REFRESH_PERIOD = 1000000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_CH*COLOUR_W-1:0]   colour_fat,
    input  logic [N_CH*COLOUR_W-1:0]   colour_muscle,
    input  logic [N_CH*COORD_W-1:0]    x_base,
    input  logic [N_CH*COORD_W-1:0]    y_base,
    input  logic                       plot_ready,
    output logic [COORD_W-1:0]         x_out,
    output logic [COORD_W-1:0]         y_out,
    output logic [COLOUR_W-1:0]        colour_out,
    output logic                       plot,
    output logic [2:0]                 cur_ch,
    output logic                       busy
);

    localparam int         SHADOW_W = 2 * COLOUR_W;
    localparam logic [2:0] PTR_LAST = 3'(N_CH - 1);

    md_state_e                         state_q, state_d;
    logic [2:0]                        ptr_q, ptr_d, ptr_next;
    logic [N_CH-1:0]                   pending_q, pending_d;
    logic [N_CH-1:0][SHADOW_W-1:0]     shadow_q, shadow_d;
    logic [COLOUR_W-1:0]               fat_q, fat_d, mus_q, mus_d;
    logic [COORD_W-1:0]                xb_q, xb_d, yb_q, yb_d;
    logic                              plot_q, plot_d;
    logic                              busy_q, busy_d;

    logic                              sel_dirty;
    logic [COLOUR_W-1:0]               sel_fat, sel_mus;
    logic [COORD_W-1:0]                sel_x, sel_y;

    logic                              walk_clear, walk_adv, walk_border, walk_last;
    logic [COORD_W-1:0]                px, py;
    logic                              refresh_wrap;

`ifdef MDS_FORCE_REFRESH_EN
    logic [31:0] refresh_q, refresh_d;

    always_comb begin
        refresh_wrap = (refresh_q == 32'(REFRESH_PERIOD - 1));
        refresh_d    = refresh_wrap ? '0 : refresh_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    assign refresh_wrap = 1'b0;
`endif

    // Decode the slot under the pointer without a variable index, so a
    // pointer value beyond N_CH-1 can never select out of range.
    always_comb begin
        sel_dirty = 1'b0;
        sel_fat   = '0;
        sel_mus   = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ptr_q == 3'(i)) begin
                sel_fat   = colour_fat[i*COLOUR_W +: COLOUR_W];
                sel_mus   = colour_muscle[i*COLOUR_W +: COLOUR_W];
                sel_x     = x_base[i*COORD_W +: COORD_W];
                sel_y     = y_base[i*COORD_W +: COORD_W];
                sel_dirty = pending_q[i] ||
                            ({colour_fat[i*COLOUR_W +: COLOUR_W],
                              colour_muscle[i*COLOUR_W +: COLOUR_W]} != shadow_q[i]);
            end
        end
    end

    assign ptr_next = (ptr_q == PTR_LAST) ? 3'd0 : ptr_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        fat_d      = fat_q;
        mus_d      = mus_q;
        xb_d       = xb_q;
        yb_d       = yb_q;
        plot_d     = plot_q;
        busy_d     = busy_q;
        walk_clear = 1'b0;
        walk_adv   = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (sel_dirty) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end else begin
                    ptr_d = ptr_next;
                end
            end
            ST_LOAD: begin
                // The snapshot is what gets drawn and later recorded as the
                // shadow; colour changes after this point cause a redraw.
                fat_d      = sel_fat;
                mus_d      = sel_mus;
                xb_d       = sel_x;
                yb_d       = sel_y;
                walk_clear = 1'b1;
                plot_d     = 1'b1;
                busy_d     = 1'b1;
                state_d    = ST_DRAW;
            end
            ST_DRAW: begin
                if (plot_ready) begin
                    walk_adv = 1'b1;
                    if (walk_last) begin
                        plot_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (ptr_q == 3'(i)) begin
                        shadow_d[i]  = {fat_q, mus_q};
                        pending_d[i] = 1'b0;
                    end
                end
                ptr_d   = ptr_next;
                state_d = ST_SCAN;
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        // A refresh tick overrides the DONE clear of the same cycle.
        if (refresh_wrap) begin
            pending_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_SCAN;
            ptr_q     <= '0;
            pending_q <= '1;
            shadow_q  <= '0;
            fat_q     <= '0;
            mus_q     <= '0;
            xb_q      <= '0;
            yb_q      <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            fat_q     <= fat_d;
            mus_q     <= mus_d;
            xb_q      <= xb_d;
            yb_q      <= yb_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
        end
    end

    sprite_pixel_walker #(
        .W (SPR_W),
        .H (SPR_H)
    ) u_walker (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (walk_clear),
        .advance   (walk_adv),
        .px        (px),
        .py        (py),
        .is_border (walk_border),
        .last      (walk_last)
    );

    // Pixel fields are pure functions of flops, so they hold while stalled.
    assign x_out      = xb_q + px;
    assign y_out      = yb_q + py;
    assign colour_out = walk_border ? fat_q : mus_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign cur_ch     = ptr_q;

endmodule

// File: tb/tb_meat_draw_scheduler.sv
// tb/tb_meat_draw_scheduler.sv - scoreboard bench for meat_draw_scheduler
module tb_meat_draw_scheduler;

    localparam int N = 6;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           plot_ready = 1'b1;
    logic [N*9-1:0] colour_fat = '0;
    logic [N*9-1:0] colour_muscle = '0;
    logic [N*8-1:0] x_base = '0;
    logic [N*8-1:0] y_base = '0;
    logic [7:0]     x_out, y_out;
    logic [8:0]     colour_out;
    logic           plot;
    logic [2:0]     cur_ch;
    logic           busy;

    always #5 clk = ~clk;

    meat_draw_scheduler dut (
        .clk           (clk),
        .resetn        (resetn),
        .colour_fat    (colour_fat),
        .colour_muscle (colour_muscle),
        .x_base        (x_base),
        .y_base        (y_base),
        .plot_ready    (plot_ready),
        .x_out         (x_out),
        .y_out         (y_out),
        .colour_out    (colour_out),
        .plot          (plot),
        .cur_ch        (cur_ch),
        .busy          (busy)
    );

    typedef struct {
        logic [2:0] ch;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] col;
    } pix_t;

    pix_t       exp_q[$];
    pix_t       spots[9];
    bit         spot_hit[9];
    int         checks = 0;
    int         errors = 0;
    int         accept_cnt = 0;
    bit         toggle_en = 1'b0;
    logic [8:0] fat[N];
    logic [8:0] mus[N];
    int         xb[N];
    int         yb[N];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic set_colour(input int ch, input logic [8:0] f, input logic [8:0] m);
        fat[ch] = f;
        mus[ch] = m;
        colour_fat[9*ch +: 9]    = f;
        colour_muscle[9*ch +: 9] = m;
    endtask

    task automatic set_base(input int ch, input int x, input int y);
        xb[ch] = x;
        yb[ch] = y;
        x_base[8*ch +: 8] = 8'(x);
        y_base[8*ch +: 8] = 8'(y);
    endtask

    // Expected raster of one slot with its current colours.
    task automatic push_slot(input int ch);
        pix_t e;
        for (int py = 0; py < 16; py++) begin
            for (int px = 0; px < 16; px++) begin
                e.ch  = 3'(ch);
                e.x   = 8'((xb[ch] + px) % 256);
                e.y   = 8'((yb[ch] + py) % 256);
                e.col = (px == 0 || px == 15 || py == 0 || py == 15) ? fat[ch] : mus[ch];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout remaining=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n, input string name);
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk({name, "_plot"}, int'(plot), 0);
        chk({name, "_busy"}, int'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accepts(input int target, input int budget, input string name);
        int n = 0;
        while (accept_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (accept_cnt < target) begin
            errors++;
            $display("FAIL %s timeout accepted=%0d required=%0d", name, accept_cnt, target);
        end
    endtask

    // Ready toggler runs late in the cycle so the main thread can hand it
    // off deterministically.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (toggle_en) plot_ready = ~plot_ready;
        end
    end

    // Monitor: every accepted pixel pops one expectation.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (resetn && plot && plot_ready) begin
                accept_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_plot ch=%0d x=%0d y=%0d col=%h required=no_plot",
                             cur_ch, x_out, y_out, colour_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ch !== cur_ch || e.x !== x_out || e.y !== y_out || e.col !== colour_out) begin
                        errors++;
                        $display("FAIL pixel actual ch=%0d x=%0d y=%0d col=%h required ch=%0d x=%0d y=%0d col=%h",
                                 cur_ch, x_out, y_out, colour_out, e.ch, e.x, e.y, e.col);
                    end
                end
                for (int s = 0; s < 9; s++) begin
                    if (!spot_hit[s] && spots[s].ch == cur_ch && spots[s].x == x_out && spots[s].y == y_out) begin
                        spot_hit[s] = 1'b1;
                        checks++;
                        if (colour_out !== spots[s].col) begin
                            errors++;
                            $display("FAIL spot%0d colour actual=%h required=%h", s, colour_out, spots[s].col);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int base;

        // Hand-computed pixels: slot 2 at (20,40), slot 5 at (250,200) wrapping in x.
        spots[0] = '{3'd2, 8'd20,  8'd40,  9'h1C0};
        spots[1] = '{3'd2, 8'd21,  8'd41,  9'h038};
        spots[2] = '{3'd2, 8'd35,  8'd55,  9'h1C0};
        spots[3] = '{3'd2, 8'd34,  8'd54,  9'h038};
        spots[4] = '{3'd5, 8'd255, 8'd200, 9'h155};
        spots[5] = '{3'd5, 8'd0,   8'd201, 9'h0AA};
        spots[6] = '{3'd5, 8'd9,   8'd215, 9'h155};
        spots[7] = '{3'd5, 8'd250, 8'd205, 9'h155};
        spots[8] = '{3'd5, 8'd1,   8'd205, 9'h0AA};
        for (int s = 0; s < 9; s++) spot_hit[s] = 1'b0;

        set_base(0, 0, 0);      set_colour(0, 9'h100, 9'h001);
        set_base(1, 30, 0);     set_colour(1, 9'h102, 9'h003);
        set_base(2, 20, 40);    set_colour(2, 9'h1C0, 9'h038);
        set_base(3, 60, 60);    set_colour(3, 9'h104, 9'h005);
        set_base(4, 100, 100);  set_colour(4, 9'h106, 9'h007);
        set_base(5, 250, 200);  set_colour(5, 9'h155, 9'h0AA);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_colour_out", int'(colour_out), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_cur_ch", int'(cur_ch), 0);
        chk("rst_busy", int'(busy), 0);

        // Full initial draw, slots in order
        for (int c = 0; c < N; c++) push_slot(c);
        @(posedge clk);
        #1 resetn = 1'b1;
        drain(2200, "initial_draw");
        idle(40, "settled");

        // Only slot 4 changes
        set_colour(4, fat[4], 9'h0F0);
        push_slot(4);
        drain(400, "slot4_redraw");
        idle(40, "after_slot4");

        // Stalls every other cycle
        set_colour(3, 9'h1E1, mus[3]);
        push_slot(3);
        toggle_en = 1'b1;
        drain(1000, "stall_redraw");
        toggle_en  = 1'b0;
        plot_ready = 1'b1;
        idle(40, "after_stall");

        // Colour changes mid-draw: snapshot kept, redraw on next turn
        set_colour(1, 9'h111, mus[1]);
        push_slot(1);
        base = accept_cnt;
        wait_accepts(base + 100, 400, "mid_draw_wait");
        set_colour(1, 9'h122, mus[1]);
        push_slot(1);
        drain(1000, "mid_draw_redraw");
        idle(40, "after_mid_draw");

        // Colour flips away and back before the slot's turn: no redraw
        set_colour(0, 9'h0FF, mus[0]);
        set_colour(0, 9'h100, mus[0]);
        idle(40, "revert_no_redraw");

        // Reset in the middle of a draw
        set_colour(0, fat[0], 9'h0C3);
        push_slot(0);
        base = accept_cnt;
        wait_accepts(base + 50, 400, "abort_wait");
        resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_plot", int'(plot), 0);
        chk("abort_cur_ch", int'(cur_ch), 0);
        chk("abort_busy", int'(busy), 0);
        for (int c = 0; c < N; c++) push_slot(c);
        @(posedge clk);
        #1 resetn = 1'b1;
        drain(2200, "post_reset_redraw");
        idle(40, "final");

        for (int s = 0; s < 9; s++) chk($sformatf("spot%0d_seen", s), int'(spot_hit[s]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
